// File: rtl/fifo_fwft_param.sv
// First-word-fall-through FIFO with thresholds, sticky error flags and peak-occupancy tracking.
// Status and dout are combinational from registered state; a write refused while full is dropped and flagged.
module fifo_fwft_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             din,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         err_clr,
  output logic [$clog2(DEPTH+1)-1:0]   peak
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    nxt_count;
  logic             do_wr;
  logic             do_rd;

  assign count        = count_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign dout         = empty ? '0 : mem[rptr];

  // A read frees a slot in the same cycle, so a full FIFO can still accept a write alongside it.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_comb begin
    nxt_count = count_q;
    if (flush) begin
      nxt_count = '0;
    end else begin
      case ({do_wr, do_rd})
        2'b10:   nxt_count = count_q + CW'(1);
        2'b01:   nxt_count = count_q - CW'(1);
        default: nxt_count = count_q;
      endcase
    end
  end

  // Storage is deliberately not reset; count and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_wr) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      peak      <= '0;
    end else begin
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (do_wr) wptr <= wptr + AW'(1);
        if (do_rd) rptr <= rptr + AW'(1);
      end
      count_q <= nxt_count;

      // New error events take precedence over a coincident clear.
      if (!flush && wr_en && !do_wr) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (!flush && rd_en && empty) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end

      if (err_clr) begin
        peak <= nxt_count;
      end else if (nxt_count > peak) begin
        peak <= nxt_count;
      end
    end
  end

endmodule

// File: tb/tb_fifo_fwft_param.sv
// Directed bench: vector table for the 8x8 instance, hand sequences for a 32x16 instance with custom thresholds.
module tb_fifo_fwft_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [7:0]  din = '0;
  logic [31:0] din_b = '0;

  logic [7:0]  dout;
  logic        full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0]  count, peak;

  logic [31:0] dout_b;
  logic        full_b, empty_b, af_b, ae_b, ov_b, un_b;
  logic [4:0]  count_b, peak_b;

  fifo_fwft_param #(.WIDTH(8), .DEPTH(8)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .full(full), .empty(empty), .count(count),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr), .peak(peak)
  );

  fifo_fwft_param #(.WIDTH(32), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din_b), .rd_en(rd_en),
    .dout(dout_b), .full(full_b), .empty(empty_b), .count(count_b),
    .almost_full(af_b), .almost_empty(ae_b),
    .overflow(ov_b), .underflow(un_b), .err_clr(err_clr), .peak(peak_b)
  );

  typedef struct packed {
    logic [7:0] dout;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ov;
    logic       un;
    logic [3:0] peak;
  } out8_t;

  typedef struct {
    string      name;
    bit         rst, flush, wr, rd, clr;
    logic [7:0] din;
    out8_t      exp;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   nmis = 0;

  task automatic add(string nm, bit r, bit f, bit w, logic [7:0] d, bit rd, bit c,
                     logic [7:0] edout, int ecnt, bit eov, bit eun, int epk);
    vec_t v;
    v.name = nm; v.rst = r; v.flush = f; v.wr = w; v.din = d; v.rd = rd; v.clr = c;
    v.exp.dout  = edout;
    v.exp.count = 4'(ecnt);
    v.exp.full  = (ecnt == 8);
    v.exp.empty = (ecnt == 0);
    v.exp.af    = (ecnt >= 7);
    v.exp.ae    = (ecnt <= 1);
    v.exp.ov    = eov;
    v.exp.un    = eun;
    v.exp.peak  = 4'(epk);
    vecs.push_back(v);
  endtask

  task automatic step(bit r, bit f, bit w, logic [31:0] d, bit rd, bit c);
    rst = r; flush = f; wr_en = w; din_b = d; din = d[7:0]; rd_en = rd; err_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(string nm, logic [31:0] ed, int ec, bit eov, bit eun, int epk);
    logic [43:0] got, want;
    got  = {dout_b, count_b, full_b, empty_b, af_b, ae_b, ov_b, un_b};
    want = {ed, 5'(ec), ec == 16, ec == 0, ec >= 12, ec <= 4, eov, eun};
    nvec++;
    if (got !== want || peak_b !== 5'(epk)) begin
      nmis++;
      $display("FAIL %s: got dout=%h cnt=%0d f/e/af/ae/ov/un=%b peak=%0d, want dout=%h cnt=%0d f/e/af/ae/ov/un=%b peak=%0d",
               nm, dout_b, count_b, got[5:0], peak_b, ed, ec, want[5:0], epk);
    end
  endtask

  initial begin
    out8_t obs;
    int    pk;

    // Basic FWFT: three writes, three reads.
    add("rst",      1,0,0,8'h00,0,0, 8'h00,0,0,0,0);
    add("wr11",     0,0,1,8'h11,0,0, 8'h11,1,0,0,1);
    add("wr22",     0,0,1,8'h22,0,0, 8'h11,2,0,0,2);
    add("wr33",     0,0,1,8'h33,0,0, 8'h11,3,0,0,3);
    add("rd1",      0,0,0,8'h00,1,0, 8'h22,2,0,0,3);
    add("rd2",      0,0,0,8'h00,1,0, 8'h33,1,0,0,3);
    add("rd3",      0,0,0,8'h00,1,0, 8'h00,0,0,0,3);
    // Fill to full, overflow, clear.
    for (int k = 1; k <= 8; k++)
      add("fill", 0,0,1,8'(k),0,0, 8'h01,k,0,0, (k > 3) ? k : 3);
    add("ovf",      0,0,1,8'h09,0,0, 8'h01,8,1,0,8);
    add("clr_ovf",  0,0,0,8'h00,0,1, 8'h01,8,0,0,8);
    // Full with simultaneous write and read; pointers wrap.
    for (int k = 1; k <= 8; k++)
      add("full_wr_rd", 0,0,1,8'hAA,1,0, (k < 8) ? 8'(k + 1) : 8'hAA, 8,0,0,8);
    for (int k = 1; k <= 8; k++)
      add("drain", 0,0,0,8'h00,1,0, (k < 8) ? 8'hAA : 8'h00, 8 - k,0,0,8);
    add("clr_peak", 0,0,0,8'h00,0,1, 8'h00,0,0,0,0);
    // Empty with simultaneous write and read, underflow stickiness.
    add("empty_wr_rd", 0,0,1,8'h5C,1,0, 8'h5C,1,0,1,1);
    add("rd_last",  0,0,0,8'h00,1,0, 8'h00,0,0,1,1);
    add("rd_empty", 0,0,0,8'h00,1,0, 8'h00,0,0,1,1);
    add("clr_vs_udf", 0,0,0,8'h00,1,1, 8'h00,0,0,1,0);
    add("clr_udf",  0,0,0,8'h00,0,1, 8'h00,0,0,0,0);
    // Flush keeps peak and ignores the port requests.
    for (int k = 1; k <= 5; k++)
      add("load5", 0,0,1,8'(8'h40 + k),0,0, 8'h41,k,0,0,k);
    add("flush_wr", 0,1,1,8'hFF,0,0, 8'h00,0,0,0,5);
    add("flush_rd", 0,1,0,8'h00,1,0, 8'h00,0,0,0,5);
    // Reset mid-burst with flags set.
    for (int k = 1; k <= 8; k++)
      add("refill", 0,0,1,8'(8'h60 + k),0,0, 8'h61,k,0,0, (k > 5) ? k : 5);
    add("ovf2",     0,0,1,8'h70,0,0, 8'h61,8,1,0,8);
    add("rst_mid",  1,0,1,8'h71,1,1, 8'h00,0,0,0,0);
    add("post_rst", 0,0,0,8'h00,0,0, 8'h00,0,0,0,0);
    add("wr_after_rst", 0,0,1,8'h99,0,0, 8'h99,1,0,0,1);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].flush, vecs[i].wr, {24'h0, vecs[i].din}, vecs[i].rd, vecs[i].clr);
      obs = {dout, count, full, empty, almost_full, almost_empty, overflow, underflow, peak};
      nvec++;
      if (obs !== vecs[i].exp) begin
        nmis++;
        $display("FAIL %s #%0d: got %h, want %h (dout,count,f,e,af,ae,ov,un,peak)",
                 vecs[i].name, i, obs, vecs[i].exp);
      end
    end

    // Wide/deep instance: basic FWFT.
    step(1,0,0,32'h0,0,0);             chk_b("b_rst", 32'h0, 0, 0, 0, 0);
    step(0,0,1,32'h1111_1111,0,0);     chk_b("b_wr1", 32'h1111_1111, 1, 0, 0, 1);
    step(0,0,1,32'h2222_2222,0,0);     chk_b("b_wr2", 32'h1111_1111, 2, 0, 0, 2);
    step(0,0,1,32'h3333_3333,0,0);     chk_b("b_wr3", 32'h1111_1111, 3, 0, 0, 3);
    step(0,0,0,32'h0,1,0);             chk_b("b_rd1", 32'h2222_2222, 2, 0, 0, 3);
    step(0,0,0,32'h0,1,0);             chk_b("b_rd2", 32'h3333_3333, 1, 0, 0, 3);
    step(0,0,0,32'h0,1,0);             chk_b("b_rd3", 32'h0, 0, 0, 0, 3);

    // Fill: almost_empty drops at 5, almost_full rises at 12.
    for (int k = 1; k <= 16; k++) begin
      step(0,0,1,32'hA000_0000 + 32'(k),0,0);
      pk = (k > 3) ? k : 3;
      chk_b("b_fill", 32'hA000_0001, k, 0, 0, pk);
    end
    step(0,0,1,32'hDEAD_BEEF,0,0);     chk_b("b_ovf", 32'hA000_0001, 16, 1, 0, 16);
    step(0,0,0,32'h0,0,1);             chk_b("b_clr", 32'hA000_0001, 16, 0, 0, 16);

    // Full with simultaneous write and read, then drain in order.
    for (int k = 1; k <= 16; k++) begin
      step(0,0,1,32'hB000_0000 + 32'(k),1,0);
      chk_b("b_full_wr_rd", (k < 16) ? 32'hA000_0001 + 32'(k) : 32'hB000_0001, 16, 0, 0, 16);
    end
    for (int k = 1; k <= 16; k++) begin
      step(0,0,0,32'h0,1,0);
      chk_b("b_drain", (k < 16) ? 32'hB000_0001 + 32'(k) : 32'h0, 16 - k, 0, 0, 16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
